// File: rtl/ssd_bcd_counter_pkg.sv
// rtl/ssd_bcd_counter_pkg.sv - shared widths, segment codes and BCD helpers
package ssd_bcd_counter_pkg;

   localparam int DIGIT_W = 4;
   localparam int SEG_W   = 7;

   // active-low, bit0 = a .. bit6 = g
   localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   function automatic logic [31:0] to_bcd(input int unsigned v);
      logic [31:0] r;
      int unsigned x;
      r = '0;
      x = v;
      for (int k = 0; k < 8; k++) begin
         r[k*DIGIT_W +: DIGIT_W] = DIGIT_W'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

endpackage

// File: rtl/ssd_digit_decode.sv
// rtl/ssd_digit_decode.sv - one BCD digit to active-low seven-segment code
module ssd_digit_decode
   import ssd_bcd_counter_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   input  logic               blank,
   output logic [SEG_W-1:0]   seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/ssd_bcd_counter.sv
// rtl/ssd_bcd_counter.sv - prescaled multi-digit BCD up/down counter with registered HEX outputs
module ssd_bcd_counter
   import ssd_bcd_counter_pkg::*;
#(
   parameter int DIGITS    = 2,
   parameter int MAX_COUNT = 10,
   parameter int PRESCALE  = 50000000,
   parameter int BLANK_LZ  = 1
)
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      up,
   input  logic                      clear,
   input  logic                      load,
   input  logic [DIGIT_W*DIGITS-1:0] load_val,
   output logic [DIGIT_W*DIGITS-1:0] count_bcd,
   output logic [SEG_W*DIGITS-1:0]   hex,
   output logic                      wrap,
   output logic                      load_err
);

   localparam int CW = DIGIT_W * DIGITS;
   localparam int HW = SEG_W * DIGITS;
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX     = PW'(PRESCALE - 1);
   localparam logic [31:0]   MAX_BCD32 = to_bcd(MAX_COUNT);
   localparam logic [CW-1:0] MAX_BCD  = MAX_BCD32[CW-1:0];

   function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      logic          c;
      r = v;
      c = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (c) begin
            if (v[k*DIGIT_W +: DIGIT_W] == 4'd9) begin
               r[k*DIGIT_W +: DIGIT_W] = 4'd0;
            end else begin
               r[k*DIGIT_W +: DIGIT_W] = v[k*DIGIT_W +: DIGIT_W] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      logic          b;
      r = v;
      b = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (b) begin
            if (v[k*DIGIT_W +: DIGIT_W] == 4'd0) begin
               r[k*DIGIT_W +: DIGIT_W] = 4'd9;
            end else begin
               r[k*DIGIT_W +: DIGIT_W] = v[k*DIGIT_W +: DIGIT_W] - 4'd1;
               b = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic nibbles_ok(input logic [CW-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int k = 0; k < DIGITS; k++)
         if (v[k*DIGIT_W +: DIGIT_W] > 4'd9) ok = 1'b0;
      return ok;
   endfunction

   function automatic logic [HW-1:0] hex_reset();
      logic [HW-1:0] r;
      for (int k = 0; k < DIGITS; k++)
         r[k*SEG_W +: SEG_W] = (k == 0 || BLANK_LZ == 0) ? SEG_0 : SEG_BLANK;
      return r;
   endfunction

   logic [PW-1:0]     presc, presc_nxt;
   logic [CW-1:0]     count_nxt;
   logic [HW-1:0]     hex_nxt;
   logic [DIGITS-1:0] blank;
   logic              step, load_ok, wrap_nxt, err_nxt, hi_zero;

   always_comb begin
      step      = en && (presc == PMAX);
      // valid BCD orders the same as unsigned binary, so a plain compare suffices
      load_ok   = nibbles_ok(load_val) && (load_val <= MAX_BCD);
      count_nxt = count_bcd;
      presc_nxt = presc;
      wrap_nxt  = 1'b0;
      err_nxt   = 1'b0;
      if (clear) begin
         count_nxt = '0;
         presc_nxt = '0;
      end else if (load) begin
         presc_nxt = '0;
         if (load_ok) count_nxt = load_val;
         else         err_nxt   = 1'b1;
      end else if (step) begin
         presc_nxt = '0;
         if (up) begin
            if (count_bcd == MAX_BCD) begin
               count_nxt = '0;
               wrap_nxt  = 1'b1;
            end else begin
               count_nxt = bcd_inc(count_bcd);
            end
         end else begin
            if (count_bcd == '0) begin
               count_nxt = MAX_BCD;
               wrap_nxt  = 1'b1;
            end else begin
               count_nxt = bcd_dec(count_bcd);
            end
         end
      end else if (en) begin
         presc_nxt = presc + PW'(1);
      end
   end

   // blank is derived from the next count so hex lands on the same edge as count_bcd
   always_comb begin
      blank   = '0;
      hi_zero = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         hi_zero  = hi_zero && (count_nxt[k*DIGIT_W +: DIGIT_W] == 4'd0);
         blank[k] = (BLANK_LZ != 0) && hi_zero;
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_dec
      ssd_digit_decode u_dec (
         .digit (count_nxt[g*DIGIT_W +: DIGIT_W]),
         .blank (blank[g]),
         .seg   (hex_nxt[g*SEG_W +: SEG_W])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc     <= '0;
         count_bcd <= '0;
         hex       <= hex_reset();
         wrap      <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         presc     <= presc_nxt;
         count_bcd <= count_nxt;
         hex       <= hex_nxt;
         wrap      <= wrap_nxt;
         load_err  <= err_nxt;
      end
   end

endmodule

// File: tb/tb_ssd_bcd_counter.sv
// tb/tb_ssd_bcd_counter.sv - self-checking bench for ssd_bcd_counter (2 digits, max 10, prescale 4)
module tb_ssd_bcd_counter;

   localparam int DIGITS = 2;
   localparam int MAXC   = 10;
   localparam int PRE    = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0, up = 1'b0, clear = 1'b0, load = 1'b0;
   logic [7:0]  load_val = 8'h00;
   logic [7:0]  count_bcd;
   logic [13:0] hex;
   logic        wrap, load_err;

   int checks = 0;
   int failures = 0;
   bit chk_on = 1'b0;

   logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   int m_cnt = 0;
   int m_pre = 0;
   bit m_wrap = 1'b0;
   bit m_err = 1'b0;

   ssd_bcd_counter #(
      .DIGITS(DIGITS), .MAX_COUNT(MAXC), .PRESCALE(PRE), .BLANK_LZ(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
      .load_val(load_val), .count_bcd(count_bcd), .hex(hex),
      .wrap(wrap), .load_err(load_err)
   );

   always #5 clk = ~clk;

   function automatic int bcd2int(input logic [7:0] v);
      return int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [7:0] int2bcd(input int v);
      logic [3:0] hi, lo;
      hi = 4'((v / 10) % 10);
      lo = 4'(v % 10);
      return {hi, lo};
   endfunction

   function automatic logic [13:0] exp_hex(input int v);
      int d0, d1;
      logic [6:0] s1;
      d0 = v % 10;
      d1 = (v / 10) % 10;
      s1 = (d1 == 0) ? 7'h7F : segtab[d1];
      return {s1, segtab[d0]};
   endfunction

   // reference model: integer count value, wrap arithmetic modulo MAXC+1
   always @(posedge clk) begin
      m_wrap <= 1'b0;
      m_err  <= 1'b0;
      if (!rst_n) begin
         m_cnt <= 0;
         m_pre <= 0;
      end else if (clear) begin
         m_cnt <= 0;
         m_pre <= 0;
      end else if (load) begin
         m_pre <= 0;
         if (load_val[7:4] <= 9 && load_val[3:0] <= 9 && bcd2int(load_val) <= MAXC)
            m_cnt <= bcd2int(load_val);
         else
            m_err <= 1'b1;
      end else if (en) begin
         if (m_pre == PRE - 1) begin
            m_pre <= 0;
            if (up) begin
               m_cnt  <= (m_cnt + 1) % (MAXC + 1);
               m_wrap <= (m_cnt == MAXC);
            end else begin
               m_cnt  <= (m_cnt + MAXC) % (MAXC + 1);
               m_wrap <= (m_cnt == 0);
            end
         end else begin
            m_pre <= m_pre + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         checks += 4;
         if (count_bcd !== int2bcd(m_cnt)) begin
            failures++;
            $display("FAIL model_count t=%0t got=%h exp=%h", $time, count_bcd, int2bcd(m_cnt));
         end
         if (hex !== exp_hex(m_cnt)) begin
            failures++;
            $display("FAIL model_hex t=%0t got=%h exp=%h", $time, hex, exp_hex(m_cnt));
         end
         if (wrap !== m_wrap) begin
            failures++;
            $display("FAIL model_wrap t=%0t got=%b exp=%b", $time, wrap, m_wrap);
         end
         if (load_err !== m_err) begin
            failures++;
            $display("FAIL model_load_err t=%0t got=%b exp=%b", $time, load_err, m_err);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic lit(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   int wraps;

   initial begin
      tick(2);
      rst_n = 1'b1;
      chk_on = 1'b1;
      lit("reset_count", 16'(count_bcd), 16'h0000);
      lit("reset_hex", 16'(hex), 16'h3FC0);
      lit("reset_pulses", {14'd0, wrap, load_err}, 16'h0000);

      // count up through a full cycle: 11 steps at 4 cycles each
      en = 1'b1; up = 1'b1;
      wraps = 0;
      for (int i = 0; i < 44; i++) begin
         tick(1);
         if (wrap) wraps++;
         if (count_bcd == 8'h10) lit("hex_at_10", 16'(hex), 16'h3CC0);
         if (count_bcd == 8'h05) lit("hex_at_05", 16'(hex), 16'h3F92);
      end
      lit("up_wrap_count", 16'(count_bcd), 16'h0000);
      lit("up_wrap_pulses", 16'(wraps), 16'd1);

      // down from 00 wraps to MAX, then borrows to 09
      up = 1'b0;
      tick(4);
      lit("down_wrap_count", 16'(count_bcd), 16'h0010);
      lit("down_wrap_pulse", {15'd0, wrap}, 16'h0001);
      tick(4);
      lit("down_09_count", 16'(count_bcd), 16'h0009);
      lit("down_09_hex", 16'(hex), 16'h3F90);

      // load restarts the prescaler
      en = 1'b0;
      tick(1);
      load = 1'b1; load_val = 8'h07; en = 1'b1; up = 1'b1;
      tick(1);
      load = 1'b0;
      lit("load_07_count", 16'(count_bcd), 16'h0007);
      lit("load_07_hex", 16'(hex), 16'h3FF8);
      tick(3);
      lit("load_no_step_yet", 16'(count_bcd), 16'h0007);
      tick(1);
      lit("load_step_08", 16'(count_bcd), 16'h0008);

      // rejected loads
      en = 1'b0;
      load = 1'b1; load_val = 8'h1A;
      tick(1);
      load = 1'b0;
      lit("bad_nibble_err", {15'd0, load_err}, 16'h0001);
      lit("bad_nibble_count", 16'(count_bcd), 16'h0008);
      load = 1'b1; load_val = 8'h11;
      tick(1);
      load = 1'b0;
      lit("over_max_err", {15'd0, load_err}, 16'h0001);
      tick(1);
      lit("err_one_cycle", {15'd0, load_err}, 16'h0000);

      // clear beats load
      load = 1'b1; load_val = 8'h05;
      tick(1);
      lit("load_05", 16'(count_bcd), 16'h0005);
      clear = 1'b1; load_val = 8'h07;
      tick(1);
      clear = 1'b0; load = 1'b0;
      lit("clear_load_count", 16'(count_bcd), 16'h0000);
      lit("clear_load_pulses", {14'd0, wrap, load_err}, 16'h0000);

      // enable pause freezes the prescaler at 2
      en = 1'b1; up = 1'b1;
      tick(2);
      en = 1'b0;
      tick(10);
      lit("pause_count", 16'(count_bcd), 16'h0000);
      en = 1'b1;
      tick(1);
      lit("resume_no_step", 16'(count_bcd), 16'h0000);
      tick(1);
      lit("resume_step", 16'(count_bcd), 16'h0001);

      // reset mid-prescale discards the pending step
      en = 1'b0;
      load = 1'b1; load_val = 8'h06;
      tick(1);
      load = 1'b0; en = 1'b1;
      tick(3);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      lit("midreset_count", 16'(count_bcd), 16'h0000);
      lit("midreset_hex", 16'(hex), 16'h3FC0);
      lit("midreset_wrap", {15'd0, wrap}, 16'h0000);
      en = 1'b0;
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ssd_bcd_counter.md
Name: ssd_bcd_counter

Overview:
- Parametrised multi-digit BCD up/down counter with a built-in prescaler and registered seven-segment outputs, one 7-bit field per HEX display.
- Generalises the single-digit 0..10 HEX decoder to N digits, configurable wrap value, count direction, synchronous load/clear and optional leading-zero blanking.
- Sits between the board pushbutton/switch logic and the HEX pins; drives them directly.

Parameters:
- DIGITS, 2, number of BCD digits / HEX displays driven (1..8).
- MAX_COUNT, 10, highest displayed value (inclusive); must be < 10**DIGITS.
- PRESCALE, 50000000, clk cycles per count step (>=1); 1 means step every enabled cycle.
- BLANK_LZ, 1, 1 = leading-zero digits blanked (least significant digit never blanked).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- en  input  1  count enable; gates prescaler and stepping
- up  input  1  1 = increment, 0 = decrement
- clear  input  1  synchronous clear to 0
- load  input  1  synchronous load of load_val
- load_val  input  4*DIGITS  BCD value to load, digit 0 in bits [3:0]
- count_bcd  output  4*DIGITS  current count, BCD, digit 0 in [3:0]
- hex  output  7*DIGITS  active-low segments, digit k in [7k+6:7k], bit order a..g = bit0..bit6
- wrap  output  1  one-cycle pulse on the cycle count wraps (either direction)
- load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Single clock domain, clk. Reset is synchronous, active-low (rst_n sampled on clk rising edge).
- Reset: prescaler=0, count_bcd=0, wrap=0, load_err=0, hex = digit-0 shows "0" (7'h40), other digits blank (7'h7F) if BLANK_LZ else "0".
- Prescaler: counts 0..PRESCALE-1 while en=1, holds while en=0; step strobe asserts in the cycle prescaler==PRESCALE-1, and prescaler returns to 0.
- Priority per cycle: rst_n low > clear > load > step. clear and load both reset prescaler to 0.
- clear: count_bcd <= 0 next edge; no wrap pulse.
- load: accepted only if every nibble <=9 and value <= MAX_COUNT; otherwise count unchanged, load_err=1 next cycle.
- Step up: count==MAX_COUNT -> 0 with wrap=1; else BCD +1 with decimal carry (…9 -> …0, next digit +1).
- Step down: count==0 -> MAX_COUNT with wrap=1; else BCD -1 with decimal borrow (…0 -> …9).
- up sampled on the step cycle only; changing up mid-prescale is legal.
- count_bcd updates on the edge after the step/load/clear cycle; hex is registered from the next count, so hex and count_bcd change on the same edge (no extra latency between them).
- Segment map (active-low, g..a): 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10 (hex). Nibbles 10..15 cannot occur; decoder outputs blank (7F) for them.
- Leading-zero blanking: digit k>0 blank iff it and all higher digits are 0.
- wrap, load_err: pulses, 1 for exactly one cycle, 0 otherwise.
- Reset asserted mid-prescale or mid-load: all state returns to reset values on that edge; pending step is discarded.

Decomposition:
- Shared package/include: segment constants SEG_0..SEG_9, SEG_BLANK, digit width constant (4) and segment width (7).
- One sub-module: ssd_digit_decode (combinational 4-bit BCD -> 7-bit active-low segments, blank input), instantiated DIGITS times via generate.
- BCD inc/dec as functions in the top module.

Test Plan:
- (DIGITS=2, MAX=10, PRESCALE=4) reset then en=1, up=1 for 44 cycles -> count 00..10 then 00, wrap pulse once on 10->00, hex digit1 blank for 0..9 and 7'h79 at 10.
- up=0 from 00 -> next step count=10 with wrap=1; then 09, hex = {7F,10}.
- load_val=8'h07 with load=1 -> count=07 next edge, prescaler restarts (next step 4 cycles later); load_val=8'h1A or 8'h11 -> load_err=1, count unchanged.
- clear and load same cycle at count 05 -> count=00, no load_err, no wrap.
- en toggled 1->0 at prescaler=2 for 10 cycles -> count frozen, step resumes 1 cycle after en returns.
- rst_n low for one cycle mid-count (count=06, prescaler=3) -> count=00, hex={7F,40}, no wrap pulse.
